// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad constants, key indices, column states and key encoder.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;
  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_1 = 4'd0;
  localparam logic [3:0] KEY_2 = 4'd1;
  localparam logic [3:0] KEY_3 = 4'd2;
  localparam logic [3:0] KEY_4 = 4'd3;
  localparam logic [3:0] KEY_5 = 4'd4;
  localparam logic [3:0] KEY_6 = 4'd5;
  localparam logic [3:0] KEY_7 = 4'd6;
  localparam logic [3:0] KEY_8 = 4'd7;
  localparam logic [3:0] KEY_9 = 4'd8;
  localparam logic [3:0] KEY_STAR = 4'd9;
  localparam logic [3:0] KEY_0 = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  typedef enum logic [1:0] {COL0, COL1, COL2} col_e;
  function automatic logic [3:0] key_encode(input logic [NUM_ROWS*NUM_COLS-1:0] k);
    key_encode = KEY_NONE;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++)
      if (k[i]) key_encode = 4'(i);
  endfunction
endpackage

// File: rtl/scan_tick.sv
// scan_tick: column dwell counter, pulses tick on its terminal count.
module scan_tick #(
  parameter int SCAN_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = $clog2(SCAN_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(SCAN_DIV - 1);
  always_comb cnt_d = tick ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 3x4 keypad column scan with ghost reject, frame debounce
// and one-hot key output with a new-key strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_row,
  output logic [2:0]  key_col,
  output logic [11:0] key_data,
  output logic [3:0]  key_code,
  output logic        key_valid
);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int NK = NUM_ROWS * NUM_COLS;
  logic tick, frame_done, accept;
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  col_e col_q, col_d;
  logic [NK-1:0] frame_q, frame_d, clean, cand_q, cand_d, key_data_q, key_data_d;
  logic [SW-1:0] stable_q, stable_d;
  logic key_valid_q, key_valid_d;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (.clk(clk), .rst(rst), .tick(tick));

  always_comb begin
    frame_d = frame_q;
    if (tick)
      for (int r = 0; r < NUM_ROWS; r++) frame_d[r*NUM_COLS + int'(col_q)] = row_s2_q[r];
    frame_done = tick && col_q == COL2;
    // more than one bit set means a multi-key press or ghost: treat as no key
    clean = |(frame_d & (frame_d - NK'(1))) ? '0 : frame_d;
    cand_d = frame_done ? clean : cand_q;
    stable_d = !frame_done ? stable_q :
               clean != cand_q ? SW'(1) :
               stable_q == SW'(DEBOUNCE_SCANS) ? stable_q : stable_q + SW'(1);
    accept = frame_done && stable_d == SW'(DEBOUNCE_SCANS) && cand_d != key_data_q;
    key_data_d = accept ? cand_d : key_data_q;
    key_valid_d = accept && |cand_d;
    col_d = !tick ? col_q : col_q == COL0 ? COL1 : col_q == COL1 ? COL2 : COL0;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      row_s1_q <= '0;
      row_s2_q <= '0;
      col_q <= COL0;
      frame_q <= '0;
      cand_q <= '0;
      stable_q <= '0;
      key_data_q <= '0;
      key_valid_q <= 1'b0;
    end else begin
      row_s1_q <= key_row;
      row_s2_q <= row_s1_q;
      col_q <= col_d;
      frame_q <= frame_d;
      cand_q <= cand_d;
      stable_q <= stable_d;
      key_data_q <= key_data_d;
      key_valid_q <= key_valid_d;
    end

  assign key_col = col_q == COL0 ? 3'b001 : col_q == COL1 ? 3'b010 : 3'b100;
  assign key_data = key_data_q;
  assign key_valid = key_valid_q;
  assign key_code = key_encode(key_data_q);
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: random and directed keypad stimulus against a frame-level
// reference model of scanning, ghost reject and debounce.
module tb_keypad_scanner;
  import keypad_pkg::*;
  localparam int SD = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] key_row, row_model, rnd_row;
  logic [2:0] key_col;
  logic [11:0] key_data, pressed;
  logic [3:0] key_code;
  logic key_valid;

  int vectors = 0, errors = 0, pulses = 0;

  logic [2:0] m_col;
  logic [11:0] m_data, m_fr, m_prev1, m_prev2;
  logic m_valid;
  int m_n;
  logic [11:0] m_fq[$];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
    .key_data(key_data), .key_code(key_code), .key_valid(key_valid));

  always #5 clk = ~clk;

  always_comb begin
    row_model = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_col[c] && pressed[r*3 + c]) row_model[r] = 1'b1;
  end
  assign key_row = rst ? row_model : rnd_row;

  function automatic logic [3:0] m_code(input logic [11:0] d);
    m_code = 4'hF;
    for (int i = 0; i < 12; i++) if (d == (12'd1 << i)) m_code = 4'(i);
  endfunction

  task automatic m_reset();
    m_n = 0; m_col = 3'b001; m_data = '0; m_valid = 1'b0;
    m_fr = '0; m_prev1 = '0; m_prev2 = '0; m_fq.delete();
  endtask

  // model of the clock edge about to happen, given the inputs held for it
  task automatic advance(input logic [11:0] p, input logic r);
    logic [11:0] f;
    bit eq;
    int c;
    if (!r) begin
      m_reset();
      return;
    end
    m_valid = 1'b0;
    if (m_n % SD == SD - 1) begin
      c = (m_n / SD) % 3;
      for (int i = 0; i < 12; i++) if (i % 3 == c) m_fr[i] = m_prev2[i];
      if (c == 2) begin
        f = ($countones(m_fr) > 1) ? 12'h0 : m_fr;
        m_fq.push_back(f);
        if (m_fq.size() > D) void'(m_fq.pop_front());
        eq = m_fq.size() == D;
        foreach (m_fq[k]) if (m_fq[k] != f) eq = 0;
        if (eq && f != m_data) begin
          m_data = f;
          m_valid = f != 0;
        end
      end
    end
    m_prev2 = m_prev1;
    m_prev1 = p;
    m_n++;
    m_col = 3'(1 << ((m_n / SD) % 3));
  endtask

  task automatic cyc(input logic [11:0] p, input logic r);
    @(negedge clk);
    vectors++;
    if (key_col !== m_col || key_data !== m_data || key_code !== m_code(m_data) || key_valid !== m_valid) begin
      errors++;
      $display("FAIL cycle t=%0t: col=%b data=%h code=%h valid=%b, required col=%b data=%h code=%h valid=%b",
               $time, key_col, key_data, key_code, key_valid, m_col, m_data, m_code(m_data), m_valid);
    end
    if (key_valid === 1'b1) pulses++;
    pressed = p;
    rst = r;
    rnd_row = 4'($urandom);
    advance(p, r);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] cols[24];
    logic [2:0] rot[12] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                            3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [11:0] k5, k0, p;
    int lat, len;
    k5 = 12'd1 << KEY_5;
    k0 = 12'd1 << KEY_0;
    pressed = '0; rst = 1'b0; rnd_row = '0;
    m_reset();
    repeat (5) cyc('0, 1'b0);
    chk("reset_col", int'(key_col), 1);
    chk("reset_data", int'(key_data), 0);
    chk("reset_code", int'(key_code), 15);
    chk("reset_valid", int'(key_valid), 0);

    cyc('0, 1'b1);
    cols[0] = key_col;
    for (int i = 1; i < 24; i++) begin
      cyc('0, 1'b1);
      cols[i] = key_col;
    end
    for (int i = 0; i < 24; i++) chk("rotation", int'(cols[i]), int'(rot[i % 12]));
    chk("rotation_data", int'(key_data), 0);

    pulses = 0;
    repeat (72) cyc(k5, 1'b1);
    chk("key5_data", int'(key_data), 'h010);
    chk("key5_code", int'(key_code), 4);
    chk("key5_pulses", pulses, 1);
    pulses = 0;
    repeat (36) cyc('0, 1'b1);
    chk("release_data", int'(key_data), 0);
    chk("release_code", int'(key_code), 15);
    chk("release_pulses", pulses, 0);

    pulses = 0;
    for (int f = 0; f < 8; f++) repeat (12) cyc(f % 2 == 0 ? k5 : 12'h0, 1'b1);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_data", int'(key_data), 0);

    pulses = 0;
    repeat (48) cyc(12'h011, 1'b1);
    chk("ghost_data", int'(key_data), 0);
    chk("ghost_pulses", pulses, 0);
    repeat (48) cyc(12'h001, 1'b1);
    chk("key1_data", int'(key_data), 'h001);
    chk("key1_pulses", pulses, 1);
    repeat (48) cyc(12'h800, 1'b1);
    chk("hash_data", int'(key_data), 'h800);
    chk("hash_code", int'(key_code), int'(KEY_HASH));
    chk("hash_pulses", pulses, 2);

    repeat (36) cyc('0, 1'b1);
    repeat (12) cyc(k0, 1'b1);
    cyc(k0, 1'b0);
    #1;
    chk("midrst_col", int'(key_col), 1);
    chk("midrst_data", int'(key_data), 0);
    chk("midrst_code", int'(key_code), 15);
    repeat (2) cyc(k0, 1'b0);
    cyc(k0, 1'b1);
    lat = 0;
    for (int k = 1; k <= 50 && lat == 0; k++) begin
      cyc(k0, 1'b1);
      if (key_valid === 1'b1) lat = k;
    end
    chk("midrst_latency_in_range", int'(lat >= 2*12 && lat <= 3*12 + 1), 1);
    chk("midrst_key0_data", int'(key_data), 'h400);
    chk("midrst_key0_code", int'(key_code), int'(KEY_0));

    repeat (80) begin
      case ($urandom_range(99) / 34)
        0: p = '0;
        1: p = 12'd1 << $urandom_range(11);
        default: p = (12'd1 << $urandom_range(11)) | (12'd1 << $urandom_range(11));
      endcase
      if ($urandom_range(99) < 5) repeat ($urandom_range(4, 1)) cyc(p, 1'b0);
      len = $urandom_range(40, 1);
      repeat (len) cyc(p, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
